// File: rtl/sc_output_argmax_counter.sv
// Stochastic-computing output decoder: counts ones per class over a 2^L window,
// then scans for the argmax. Optional max_count port enabled by SC_SCORE_OUT_EN.
module sc_output_argmax_counter #(
  parameter int N2 = 10,
  parameter int L  = 8,
  parameter int CW = L + 1,
  parameter int IW = $clog2(N2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N2-1:0] din,
  input  logic          start,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] class_idx
`ifdef SC_SCORE_OUT_EN
  ,
  output logic [CW-1:0] max_count
`endif
);

  localparam int LEN = 1 << L;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_SCAN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [L-1:0]    cyc_q, cyc_d;
  logic [IW-1:0]   scan_q, scan_d;
  logic [CW-1:0]   cnt_q [N2];
  logic [CW-1:0]   cnt_d [N2];
  logic [IW-1:0]   best_idx_q, best_idx_d;
  logic [CW-1:0]   best_cnt_q, best_cnt_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cyc_d      = cyc_q;
    scan_d     = scan_q;
    cnt_d      = cnt_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COUNT;
          cyc_d   = '0;
          for (int i = 0; i < N2; i++) cnt_d[i] = '0;
        end
      end
      S_COUNT: begin
        for (int i = 0; i < N2; i++) cnt_d[i] = cnt_q[i] + CW'(din[i]);
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == L'(LEN - 1)) begin
          state_d = S_SCAN;
          scan_d  = '0;
        end
      end
      S_SCAN: begin
        scan_d = scan_q + 1'b1;
        // Index 0 seeds the best; later classes win only on a strict increase,
        // so ties stay with the lowest index.
        if (scan_q == '0) begin
          best_idx_d = '0;
          best_cnt_d = cnt_q[0];
        end else if (cnt_q[scan_q] > best_cnt_q) begin
          best_idx_d = scan_q;
          best_cnt_d = cnt_q[scan_q];
        end
        if (scan_q == IW'(N2 - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      scan_q     <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      // NOTE: the counter array is flops, not RAM, so clearing it in reset is
      // cheap and guarantees an aborted window leaves nothing behind.
      for (int i = 0; i < N2; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      scan_q     <= scan_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // The best registers only move during SCAN, so they double as held outputs.
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign class_idx = best_idx_q;
`ifdef SC_SCORE_OUT_EN
  assign max_count = best_cnt_q;
`endif

endmodule

// File: tb/tb_sc_output_argmax_counter.sv
// Scoreboard bench for sc_output_argmax_counter: expected results are queued at
// start and compared when the result handshake occurs.
module tb_sc_output_argmax_counter;

  localparam int N2  = 10;
  localparam int L   = 8;
  localparam int CW  = L + 1;
  localparam int IW  = $clog2(N2);
  localparam int LEN = 1 << L;

  typedef struct {
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [N2-1:0] din;
  logic          start;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] class_idx;
`ifdef SC_SCORE_OUT_EN
  logic [CW-1:0] max_count;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  sc_output_argmax_counter #(.N2(N2), .L(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_idx (class_idx)
`ifdef SC_SCORE_OUT_EN
    ,
    .max_count (max_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Compare against the scoreboard whenever the consumer is about to accept.
  always begin
    @(negedge clk);
    #1;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("class_idx", 32'(class_idx), 32'(e.idx));
`ifdef SC_SCORE_OUT_EN
        check("max_count", 32'(max_count), 32'(e.cnt));
`endif
      end
    end
  end

  function automatic logic [N2-1:0] pat(input int p, input int k);
    logic [N2-1:0] v;
    v = '0;
    case (p)
      0: v[3] = 1'b1;
      1: begin v[2] = 1'b1; v[7] = 1'b1; end
      2: v = '0;
      3: begin v[5] = (k % 2 == 0); v[1] = (k % 4 == 3); end
      4: for (int i = 0; i < N2; i++) v[i] = ($urandom_range(0, 15) < (i + 3));
      5: v = '1;
      6: v[N2-1] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // abort_at >= 0: assert reset at that COUNT cycle. hold > 0: stall the
  // consumer for that many cycles and poke start throughout.
  task automatic run(input int p, input int abort_at, input int hold);
    logic [N2-1:0] seq [LEN];
    int            cnt [N2];
    exp_t          e;
    int            m;
    int            highs;
    logic          stable;
    logic [IW-1:0] idx0;

    for (int i = 0; i < N2; i++) cnt[i] = 0;
    for (int k = 0; k < LEN; k++) begin
      seq[k] = pat(p, k);
      for (int i = 0; i < N2; i++) cnt[i] += int'(seq[k][i]);
    end
    e.idx = '0;
    e.cnt = CW'(cnt[0]);
    for (int i = 1; i < N2; i++)
      if (cnt[i] > int'(e.cnt)) begin
        e.idx = IW'(i);
        e.cnt = CW'(cnt[i]);
      end
    if (abort_at < 0) sb_q.push_back(e);

    @(negedge clk);
    start = 1'b1;
    din   = '0;
    for (int k = 0; k < LEN; k++) begin
      @(negedge clk);
      start = (hold > 0 && k == 50);
      din   = seq[k];
      if (k == 0) check("busy_after_start", 32'(busy), 1);
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(out_valid), 0);
        check("abort_class_idx", 32'(class_idx), 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        din   = '0;
        highs = 0;
        repeat (LEN + 2 * N2) begin
          @(negedge clk);
          if (out_valid || busy) highs++;
        end
        check("abort_no_result", 32'(highs), 0);
        return;
      end
    end
    start = 1'b0;
    din   = '0;

    m = LEN - 1;
    while (!out_valid && m <= LEN + N2 + 20) begin
      @(negedge clk);
      m++;
    end
    check("latency", 32'(m), 32'(LEN + N2));
    if (!out_valid) return;

    if (hold > 0) begin
      idx0   = class_idx;
      stable = 1'b1;
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        start = (j % 5 == 0);
        if (!out_valid || class_idx !== idx0) stable = 1'b0;
      end
      check("hold_stable", 32'(stable), 1);
      @(negedge clk);
      out_ready = 1'b1;
      start     = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check("valid_drop", 32'(out_valid), 0);
    check("busy_drop", 32'(busy), 0);
    if (hold > 0) begin
      @(negedge clk);
      check("handshake_start_ignored", 32'(busy), 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    din       = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_valid", 32'(out_valid), 0);
    check("reset_class_idx", 32'(class_idx), 0);
`ifdef SC_SCORE_OUT_EN
    check("reset_max_count", 32'(max_count), 0);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_start", 32'(busy), 0);

    run(0, -1, 0);    // single hot class
    run(1, -1, 0);    // tie between classes 2 and 7
    run(2, -1, 0);    // all-zero window
    run(3, -1, 0);    // 128 vs 64 ones
    run(5, -1, 0);    // all classes saturate
    run(6, -1, 0);    // winner is last class
    run(4, -1, 0);    // random densities
    run(0, 100, 0);   // reset during COUNT
    run(0, -1, 0);    // clean run after abort
    out_ready = 1'b0;
    run(3, -1, 20);   // stalled consumer with ignored starts

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
